// File: rtl/i2c_slave_regs_pkg.sv
// Shared definitions for the I2C register-file target: FSM state encoding,
// bus bit constants and a pointer range helper.
package i2c_slave_regs_pkg;

  // Protocol phases; every *_ACK state covers the ninth clock of a byte.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } i2c_state_e;

  // Bus-level bit meanings.
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic I2C_RD   = 1'b1;
  localparam logic I2C_WR   = 1'b0;

  // Reserved general-call address.
  localparam logic [6:0] I2C_GEN_CALL_ADDR = 7'h00;

  // True when an 8-bit register pointer addresses a real register.
  function automatic logic ptr_in_range(input logic [7:0] ptr, input int num_regs);
    return ({1'b0, ptr} < 9'(num_regs));
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchroniser for one open-drain bus line, followed by
// rise/fall detection on the synchronised level. Flops reset to the idle
// bus level (1) so that leaving reset on a quiet bus produces no edges.
module i2c_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the raw line through the synchroniser and remember the last level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(din_i);
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target with a small register file. Accepts sub-address + data writes,
// serves reads (typically after a repeated START) and pulses reg_wr_valid per
// written byte. SDA is only ever pulled low via sda_oe.
// Optional build macro: I2C_SLAVE_GEN_CALL_EN -- when defined, the general
// call address 7'h00 with R/W=0 is accepted like an own-address write.
module i2c_slave_regs
  import i2c_slave_regs_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  localparam int        AW          = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_oe,
  output logic          busy,
  output logic          reg_wr_valid,
  output logic [7:0]    reg_wr_addr,
  output logic [7:0]    reg_wr_data,
  input  logic [AW-1:0] hst_addr,
  output logic [7:0]    hst_rdata
);

  // Synchronised bus view
  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_scl (
    .clk     (clk),
    .reset   (reset),
    .din_i   (scl_in),
    .level_o (scl_lvl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sda (
    .clk     (clk),
    .reset   (reset),
    .din_i   (sda_in),
    .level_o (sda_lvl),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  // State
  i2c_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;   // received bits; shift_q[0] holds R/W after ADDR
  logic [6:0] tx_q, tx_d;         // bits still to be sent after the one on the bus
  logic [7:0] ptr_q, ptr_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       wr_valid_q, wr_valid_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;

  logic [7:0] regfile_q [NUM_REGS];
  logic       rf_we;
  logic [AW-1:0] rf_waddr;

  // Byte as it stands once the current SCL rise's bit is included.
  logic [7:0] byte_in;
  assign byte_in = {shift_q, sda_lvl};

  // Address decode, including the optional general call.
  logic gen_call_hit, addr_hit;
`ifdef I2C_SLAVE_GEN_CALL_EN
  assign gen_call_hit = (byte_in[7:1] == I2C_GEN_CALL_ADDR) && (byte_in[0] == I2C_WR);
`else
  assign gen_call_hit = 1'b0;
`endif
  assign addr_hit = (byte_in[7:1] == SLAVE_ADDR) || gen_call_hit;

  // Read data for the current and next pointer; out-of-range reads as 0xFF.
  logic [7:0] ptr_nxt, rd_cur, rd_nxt;
  assign ptr_nxt = ptr_q + 8'd1;
  assign rd_cur  = ptr_in_range(ptr_q, NUM_REGS)   ? regfile_q[ptr_q[AW-1:0]]   : 8'hFF;
  assign rd_nxt  = ptr_in_range(ptr_nxt, NUM_REGS) ? regfile_q[ptr_nxt[AW-1:0]] : 8'hFF;

  assign rf_waddr = ptr_q[AW-1:0];

  // Next-state and output logic for the protocol FSM.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rf_we      = 1'b0;

    if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (start_det) begin
      // SDA can only have fallen if we were not holding it, so releasing is safe.
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sda_oe_d = 1'b0;
        end

        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (addr_hit) begin
                state_d = ST_ADDR_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end
        end

        // bit_cnt is the ACK phase: 0 = waiting for the fall after bit 8,
        // 1 = driving ACK until the fall after bit 9.
        ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              sda_oe_d  = 1'b1;
              bit_cnt_d = 4'd1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              if (state_q == ST_ADDR_ACK && shift_q[0] == I2C_RD) begin
                // First read bit goes on the bus at this same fall.
                tx_d     = rd_cur[6:0];
                sda_oe_d = ~rd_cur[7];
                state_d  = ST_RDATA;
              end else if (state_q == ST_ADDR_ACK) begin
                state_d = ST_REG;
              end else begin
                state_d = ST_WDATA;
              end
            end
          end
        end

        ST_REG: begin
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              ptr_d     = byte_in;
              state_d   = ST_REG_ACK;
            end
          end
        end

        ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d  = 4'd0;
              // Notify even when the pointer is past the register file.
              wr_valid_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = byte_in;
              rf_we      = ptr_in_range(ptr_q, NUM_REGS);
              ptr_d      = ptr_nxt;
              state_d    = ST_WDATA_ACK;
            end
          end
        end

        // bit_cnt counts bits the master has clocked in.
        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = ST_RDATA_ACK;
            end else if (bit_cnt_q != 4'd0) begin
              sda_oe_d = ~tx_q[6];
              tx_d     = {tx_q[5:0], 1'b0};
            end
          end
        end

        // Sample the master's ACK on the rise, hand over the next byte on the fall.
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_lvl == I2C_NACK) begin
              state_d = ST_IDLE;
            end else begin
              bit_cnt_d = 4'd1;
            end
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            bit_cnt_d = 4'd0;
            ptr_d     = ptr_nxt;
            tx_d      = rd_nxt[6:0];
            sda_oe_d  = ~rd_nxt[7];
            state_d   = ST_RDATA;
          end
        end

        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end

    if (state_d == ST_IDLE) begin
      busy_d = 1'b0;
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 7'd0;
      tx_q       <= 7'd0;
      ptr_q      <= 8'd0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 8'd0;
      wr_data_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Register file: cleared by reset, written when a captured byte is in range.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regfile_q[i] <= 8'd0;
      end
    end else if (rf_we) begin
      regfile_q[rf_waddr] <= byte_in;
    end
  end

  assign sda_oe       = sda_oe_q;
  assign busy         = busy_q;
  assign reg_wr_valid = wr_valid_q;
  assign reg_wr_addr  = wr_addr_q;
  assign reg_wr_data  = wr_data_q;
  assign hst_rdata    = regfile_q[hst_addr];

endmodule
